// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, ready/valid word handoff with error pulses.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  parity_err,
   output logic                  framing_err,
   output logic                  overrun_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_e;

   state_e                  state_q, state_d;
   logic                    rxMeta_q, rxSync_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        bitIdx_q, bitIdx_d;
   logic [DATA_WIDTH-1:0]   shiftReg_q, shiftReg_d;
   logic [DATA_WIDTH-1:0]   rxData_q, rxData_d;
   logic                    rxValid_q, rxValid_d;
   logic                    framingErr_q, framingErr_d;
   logic                    overrunErr_q, overrunErr_d;
   logic                    rx_s;
   logic                    halfEnd, bitEnd;
   logic                    frameDone, stopBad, loadWord;
   logic                    frameParErr;

`ifdef UART_RX_PARITY_EN
   logic                    parBad_q, parBad_d;
   logic                    parityErr_q, parityErr_d;
`endif

   assign rx_s    = rxSync_q;
   assign halfEnd = (cnt_q == HALF_LAST);
   assign bitEnd  = (cnt_q == BIT_LAST);

   // Two-stage synchronizer; flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx;
         rxSync_q <= rxMeta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (halfEnd) begin
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bitEnd && (bitIdx_q == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bitEnd) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bitEnd) begin
               state_d = rx_s ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign frameDone = (state_q == STOP) && bitEnd && rx_s;
   assign stopBad   = (state_q == STOP) && bitEnd && !rx_s;
   assign loadWord  = frameDone && (!rxValid_q || rx_ready);

`ifdef UART_RX_PARITY_EN
   assign frameParErr = parBad_q;
`else
   assign frameParErr = 1'b0;
`endif

   // The bit counter restarts on every state change and at each bit boundary, so it never wraps.
   always_comb begin
      cnt_d        = '0;
      bitIdx_d     = bitIdx_q;
      shiftReg_d   = shiftReg_q;
      rxData_d     = rxData_q;
      rxValid_d    = rxValid_q;
      framingErr_d = stopBad;
      overrunErr_d = frameDone && !loadWord;
`ifdef UART_RX_PARITY_EN
      parBad_d     = parBad_q;
      parityErr_d  = parityErr_q;
`endif

      if ((state_d == state_q) && (state_q != IDLE) && (state_q != BREAK) && !bitEnd) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (state_q == IDLE) begin
         bitIdx_d = '0;
      end

      if ((state_q == DATA) && bitEnd) begin
         shiftReg_d = {rx_s, shiftReg_q[DATA_WIDTH-1:1]};
         bitIdx_d   = (bitIdx_q == IDX_LAST) ? '0 : bitIdx_q + IDX_W'(1);
      end

`ifdef UART_RX_PARITY_EN
      if ((state_q == PARITY) && bitEnd) begin
         parBad_d = rx_s ^ (^shiftReg_q);
      end
`endif

      if (rxValid_q && rx_ready) begin
         rxValid_d = 1'b0;
      end

      if (loadWord) begin
         rxData_d  = shiftReg_q;
         rxValid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
         parityErr_d = frameParErr;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q        <= '0;
         bitIdx_q     <= '0;
         shiftReg_q   <= '0;
         rxData_q     <= '0;
         rxValid_q    <= 1'b0;
         framingErr_q <= 1'b0;
         overrunErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parBad_q     <= 1'b0;
         parityErr_q  <= 1'b0;
`endif
      end else begin
         cnt_q        <= cnt_d;
         bitIdx_q     <= bitIdx_d;
         shiftReg_q   <= shiftReg_d;
         rxData_q     <= rxData_d;
         rxValid_q    <= rxValid_d;
         framingErr_q <= framingErr_d;
         overrunErr_q <= overrunErr_d;
`ifdef UART_RX_PARITY_EN
         parBad_q     <= parBad_d;
         parityErr_q  <= parityErr_d;
`endif
      end
   end

   assign rx_data     = rxData_q;
   assign rx_valid    = rxValid_q;
   assign framing_err = framingErr_q;
   assign overrun_err = overrunErr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parityErr_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;

   localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int MAX_LATENCY = 172;
`else
   localparam int MAX_LATENCY = 156;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       framing_err;
   logic       overrun_err;

   int assertCount = 0;
   int failCount   = 0;

   int         cyc = 0;
   int         validCycles = 0;
   int         framingCount = 0;
   int         overrunCount = 0;
   int         lastValidCycle = 0;
   logic [7:0] lastData = 8'h00;
   logic       lastPar = 1'b0;

   int v0, f0, o0, startCycle;

   uart_rx #(
      .CLKS_PER_BIT(CLKS),
      .DATA_WIDTH  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .parity_err (parity_err),
      .framing_err(framing_err),
      .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse/word monitor sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         validCycles++;
         lastValidCycle = cyc;
         lastData = rx_data;
         lastPar = parity_err;
      end
      if (framing_err) framingCount++;
      if (overrun_err) overrunCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic driveLevel(input logic level, input int cycles);
      rx = level;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic flipParity,
                                input logic stopVal, input int stopBits);
      driveLevel(1'b0, CLKS);
      for (int i = 0; i < 8; i++) driveLevel(data[i], CLKS);
`ifdef UART_RX_PARITY_EN
      driveLevel((^data) ^ flipParity, CLKS);
`else
      if (flipParity) $display("[TB] note: parity flip ignored, no parity bit in this build");
`endif
      driveLevel(stopVal, CLKS * stopBits);
      driveLevel(1'b1, 2 * CLKS);
   endtask

   task automatic snap();
      v0 = validCycles;
      f0 = framingCount;
      o0 = overrunCount;
   endtask

   initial begin
      rst      = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (5) @(negedge clk);

      checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset rx_data", 32'(rx_data), 32'h00);
      checkOutput("reset parity_err", 32'(parity_err), 32'd0);
      checkOutput("reset framing_err", 32'(framing_err), 32'd0);
      checkOutput("reset overrun_err", 32'(overrun_err), 32'd0);

      rst = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] frame 0xA5 with ready high");
      snap();
      startCycle = cyc;
      applyStimulus(8'hA5, 1'b0, 1'b1, 1);
      checkOutput("A5 valid cycles", 32'(validCycles - v0), 32'd1);
      checkOutput("A5 data", 32'(lastData), 32'hA5);
      checkOutput("A5 latency in bound", 32'((lastValidCycle - startCycle) <= MAX_LATENCY), 32'd1);
      checkOutput("A5 no framing", 32'(framingCount - f0), 32'd0);
      checkOutput("A5 no overrun", 32'(overrunCount - o0), 32'd0);
      checkOutput("A5 parity_err", 32'(lastPar), 32'd0);
      checkOutput("A5 valid cleared", 32'(rx_valid), 32'd0);

      $display("[TB] start-bit glitch then 0x3C");
      snap();
      driveLevel(1'b0, 4);
      driveLevel(1'b1, 3 * CLKS);
      checkOutput("glitch no valid", 32'(validCycles - v0), 32'd0);
      checkOutput("glitch no framing", 32'(framingCount - f0), 32'd0);
      checkOutput("glitch no overrun", 32'(overrunCount - o0), 32'd0);
      applyStimulus(8'h3C, 1'b0, 1'b1, 1);
      checkOutput("3C valid cycles", 32'(validCycles - v0), 32'd1);
      checkOutput("3C data", 32'(lastData), 32'h3C);

      $display("[TB] bad stop bit on 0x81 then 0x42");
      snap();
      applyStimulus(8'h81, 1'b0, 1'b0, 2);
      checkOutput("81 framing pulse", 32'(framingCount - f0), 32'd1);
      checkOutput("81 no valid", 32'(validCycles - v0), 32'd0);
      checkOutput("81 data unchanged", 32'(rx_data), 32'h3C);
      applyStimulus(8'h42, 1'b0, 1'b1, 1);
      checkOutput("42 valid cycles", 32'(validCycles - v0), 32'd1);
      checkOutput("42 data", 32'(lastData), 32'h42);
      checkOutput("42 framing total", 32'(framingCount - f0), 32'd1);

      $display("[TB] overrun with ready low");
      snap();
      rx_ready = 1'b0;
      applyStimulus(8'h11, 1'b0, 1'b1, 1);
      checkOutput("11 valid held", 32'(rx_valid), 32'd1);
      checkOutput("11 data", 32'(rx_data), 32'h11);
      applyStimulus(8'h22, 1'b0, 1'b1, 1);
      checkOutput("22 valid held", 32'(rx_valid), 32'd1);
      checkOutput("22 data kept 11", 32'(rx_data), 32'h11);
      checkOutput("22 overrun pulse", 32'(overrunCount - o0), 32'd1);
      checkOutput("22 no framing", 32'(framingCount - f0), 32'd0);
      rx_ready = 1'b1;
      @(negedge clk);
      checkOutput("consume clears valid", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity frames 0x07");
      snap();
      applyStimulus(8'h07, 1'b1, 1'b1, 1);
      checkOutput("07 bad parity valid", 32'(validCycles - v0), 32'd1);
      checkOutput("07 bad parity data", 32'(lastData), 32'h07);
      checkOutput("07 parity_err set", 32'(lastPar), 32'd1);
      applyStimulus(8'h07, 1'b0, 1'b1, 1);
      checkOutput("07 good parity data", 32'(lastData), 32'h07);
      checkOutput("07 parity_err clear", 32'(lastPar), 32'd0);
`else
      $display("[TB] parity absent: frame 0x07");
      snap();
      applyStimulus(8'h07, 1'b0, 1'b1, 1);
      checkOutput("07 data", 32'(lastData), 32'h07);
      checkOutput("07 parity_err tied low", 32'(lastPar), 32'd0);
`endif

      $display("[TB] reset mid-frame on 0xFF then 0x5A");
      snap();
      driveLevel(1'b0, CLKS);
      for (int i = 0; i < 4; i++) driveLevel(1'b1, CLKS);
      driveLevel(1'b1, 4);
      rst = 1'b0;
      driveLevel(1'b1, 3);
      rst = 1'b1;
      checkOutput("reset clears rx_data", 32'(rx_data), 32'h00);
      driveLevel(1'b1, 9 * CLKS);
      checkOutput("FF no valid", 32'(validCycles - v0), 32'd0);
      checkOutput("FF no framing", 32'(framingCount - f0), 32'd0);
      checkOutput("FF no overrun", 32'(overrunCount - o0), 32'd0);
      applyStimulus(8'h5A, 1'b0, 1'b1, 1);
      checkOutput("5A valid cycles", 32'(validCycles - v0), 32'd1);
      checkOutput("5A data", 32'(lastData), 32'h5A);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
